// File: rtl/core_sequencer_pkg.sv
// core_pkg: sequencer state encoding, RV32 opcode constants and opcode class helpers
// shared by core_sequencer and its timeout sub-module.
package core_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } seq_state_t;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMMW   = 7'h1B;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_IMM, OP_IMMW, OP_AUIPC, OP_STORE,
                      OP_OP, OP_LUI, OP_BRANCH, OP_JAL, OP_SYSTEM};
  endfunction
  // Opcodes that produce a register result; branches, stores and SYSTEM never write.
  function automatic logic op_writes(input logic [6:0] op);
    return op inside {OP_LOAD, OP_IMM, OP_IMMW, OP_AUIPC, OP_OP, OP_LUI, OP_JAL};
  endfunction
endpackage

// File: rtl/core_sequencer_timeout.sv
// seq_timeout: saturating memory wait counter; expired flags the request cycle
// that brings the count to MEM_TIMEOUT so the FSM can leave on that edge.
module seq_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc && r_cnt != 8'(MEM_TIMEOUT)) r_cnt <= r_cnt + 8'd1;
  assign expired = inc && (r_cnt >= 8'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM owning the shared memory port.
// Optional perf counters enabled by CORE_SEQ_PERF_COUNTERS_EN; otherwise the counter ports read 0.
module core_sequencer
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  opcode,
  input  logic        MemWrite,
  input  logic        RegWriteEn,
  input  logic [1:0]  PCSel,
  input  logic        ecall_break,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        instr_ld,
  output logic        pc_we,
  output logic        pc_next_sel,
  output logic        reg_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);
  seq_state_t r_state, w_next;
  logic       r_illegal, w_req, w_expired, w_wb;
  assign w_req = r_state inside {S_FETCH, S_MEM};
  assign w_wb  = r_state == S_WB;
  // Counter stays cleared outside FETCH/MEM, so every entry starts from zero.
  seq_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!w_req || mem_ready),
    .inc     (w_req && !mem_ready),
    .expired (w_expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal || (r_state == S_DECODE && !op_legal(opcode));
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = mem_ready ? S_DECODE : w_expired ? S_FAULT : S_FETCH;
      S_DECODE: w_next = !op_legal(opcode) ? S_FAULT : ecall_break ? S_HALT : S_EXEC;
      S_EXEC:   w_next = (opcode == OP_LOAD || MemWrite) ? S_MEM : S_WB;
      S_MEM:    w_next = mem_ready ? S_WB : w_expired ? S_FAULT : S_MEM;
      S_WB:     w_next = stop ? S_IDLE : S_FETCH;
      default:  w_next = r_state;
    endcase
  end
  assign mem_req      = w_req;
  assign mem_addr_sel = r_state == S_MEM;
  assign mem_we       = r_state == S_MEM && MemWrite;
  assign instr_ld     = r_state == S_FETCH && mem_ready;
  assign pc_we        = w_wb;
  assign pc_next_sel  = w_wb && PCSel == PC_SEL_BRANCH && (opcode == OP_JAL || branch_taken);
  assign reg_we       = w_wb && RegWriteEn && op_writes(opcode);
  assign state        = r_state;
  assign halted       = r_state == S_HALT;
  assign fault        = r_state == S_FAULT;
  assign illegal      = r_illegal;
`ifdef CORE_SEQ_PERF_COUNTERS_EN
  logic [31:0] r_cycle_cnt, r_instret_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (!(r_state inside {S_IDLE, S_HALT, S_FAULT})) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_wb) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: per-instruction phase model builds the expected cycle trace
// (fetch waits, decode outcome, memory waits, writeback) and checks every output each cycle.
module tb_core_sequencer;
  logic        clk = 0, rst_n = 0, start = 0, stop = 0;
  logic [6:0]  opcode = 0;
  logic        MemWrite = 0, RegWriteEn = 0, ecall_break = 0, branch_taken = 0, mem_ready = 0;
  logic [1:0]  PCSel = 0;
  logic        mem_req, mem_we, mem_addr_sel, instr_ld, pc_we, pc_next_sel, reg_we;
  logic        halted, fault, illegal;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;
  int tot = 0, bad = 0;
  logic [6:0] legal_ops [10] = '{7'h03, 7'h13, 7'h1B, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h6F, 7'h73};
`ifdef CORE_SEQ_PERF_COUNTERS_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif
  always #5 clk = ~clk;
  core_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .opcode(opcode),
    .MemWrite(MemWrite), .RegWriteEn(RegWriteEn), .PCSel(PCSel), .ecall_break(ecall_break),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .instr_ld(instr_ld), .pc_we(pc_we), .pc_next_sel(pc_next_sel),
    .reg_we(reg_we), .state(state), .halted(halted), .fault(fault), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );
  wire [11:0] w_obs = {state, mem_req, mem_we, mem_addr_sel, instr_ld, pc_we, pc_next_sel, reg_we, halted, fault};
  function automatic bit is_legal(logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
    return 0;
  endfunction
  function automatic bit writes(logic [6:0] op);
    return op inside {7'h03, 7'h13, 7'h1B, 7'h17, 7'h33, 7'h37, 7'h6F};
  endfunction
  // Expected outputs for one cycle spent in phase st of the current instruction.
  function automatic logic [11:0] expect_out(int st, bit rdy, logic [6:0] op, bit mw, bit rwe,
                                             logic [1:0] pcs, bit bt);
    bit wb = (st == 5);
    return {3'(st), st == 1 || st == 4, st == 4 && mw, st == 4, st == 1 && rdy, wb,
            wb && pcs == 2'd1 && (op == 7'h6F || bt), wb && rwe && writes(op), st == 6, st == 7};
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; stop = 0; mem_ready = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic start_seq(input bit stp);
    @(negedge clk);
    start = 1; stop = stp; mem_ready = 1'($urandom);
    #1;
    tot++;
    if (w_obs !== 12'h0) begin
      bad++;
      $display("FAIL idle_start got=%h want=%h", w_obs, 12'h0);
    end
  endtask
  // Runs one instruction from its first FETCH cycle, checking every cycle against the phase trace.
  task automatic run_instr(input logic [6:0] op, input bit mw, input bit rwe, input logic [1:0] pcs,
                           input bit eb, input bit bt, input int fw, input int mwait, input bit stp);
    int q_st[$];
    bit q_rdy[$];
    logic [11:0] e;
    for (int i = 0; i <= fw; i++) begin q_st.push_back(1); q_rdy.push_back(i == fw); end
    q_st.push_back(2); q_rdy.push_back(1'($urandom));
    if (!is_legal(op)) begin q_st.push_back(7); q_rdy.push_back(1'($urandom)); end
    else if (eb) begin q_st.push_back(6); q_rdy.push_back(1'($urandom)); end
    else begin
      q_st.push_back(3); q_rdy.push_back(1'($urandom));
      if (op == 7'h03 || mw)
        for (int i = 0; i <= mwait; i++) begin q_st.push_back(4); q_rdy.push_back(i == mwait); end
      q_st.push_back(5); q_rdy.push_back(1'($urandom));
    end
    foreach (q_st[k]) begin
      @(negedge clk);
      if (k == 0) begin
        opcode = op; MemWrite = mw; RegWriteEn = rwe; PCSel = pcs; ecall_break = eb; branch_taken = bt;
      end
      mem_ready = q_rdy[k];
      start = 1'($urandom);
      stop = (q_st[k] == 5) ? stp : 1'($urandom);
      #1;
      e = expect_out(q_st[k], q_rdy[k], op, mw, rwe, pcs, bt);
      tot++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL instr op=%h cyc=%0d got=%h want=%h", op, k, w_obs, e);
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    tot++;
    if (w_obs !== 12'h0) begin bad++; $display("FAIL reset_outputs got=%h want=%h", w_obs, 12'h0); end
    tot++;
    if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    tot++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", cycle_cnt, instret_cnt);
    end
  endtask
  task automatic test_addi();
    start_seq(0);
    run_instr(7'h13, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    run_instr(7'h13, 0, 1, 2'd0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_load();
    run_instr(7'h03, 0, 1, 2'd0, 0, 0, 0, 3, 0);
    run_instr(7'h23, 1, 1, 2'd0, 0, 0, 2, 1, 0);
  endtask
  task automatic test_branch();
    run_instr(7'h63, 0, 1, 2'd1, 0, 1, 0, 0, 0);
    run_instr(7'h63, 0, 1, 2'd1, 0, 0, 1, 0, 0);
    run_instr(7'h6F, 0, 1, 2'd1, 0, 0, 0, 0, 1);
    start_seq(1);
  endtask
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      bit stp;
      int fw;
      op = legal_ops[$urandom_range(0, 9)];
      fw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
      stp = ($urandom_range(0, 5) == 0);
      run_instr(op, op == 7'h23 || $urandom_range(0, 7) == 0, 1'($urandom), 2'($urandom_range(0, 2)),
                0, 1'($urandom), fw, $urandom_range(0, 5), stp);
      if (stp) start_seq(1'($urandom));
    end
  endtask
  task automatic test_halt();
    run_instr(7'h73, 0, 0, 2'd0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1; stop = 1'($urandom); mem_ready = 1'($urandom);
      #1;
      tot++;
      if (w_obs !== expect_out(6, 0, 7'h73, 0, 0, 2'd0, 0)) begin
        bad++; $display("FAIL halt_hold got=%h want=%h", w_obs, expect_out(6, 0, 7'h73, 0, 0, 2'd0, 0));
      end
    end
  endtask
  task automatic test_timeout();
    do_reset();
    start_seq(0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mem_ready = 0; start = 1'($urandom);
      #1;
      tot++;
      if (w_obs !== expect_out(1, 0, opcode, 0, 0, 2'd0, 0)) begin
        bad++; $display("FAIL timeout_wait cyc=%0d got=%h want=%h", i, w_obs, expect_out(1, 0, opcode, 0, 0, 2'd0, 0));
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); start = 1;
      #1;
      tot++;
      if (w_obs !== expect_out(7, 0, opcode, 0, 0, 2'd0, 0)) begin
        bad++; $display("FAIL timeout_fault cyc=%0d got=%h want=%h", i, w_obs, expect_out(7, 0, opcode, 0, 0, 2'd0, 0));
      end
    end
  endtask
  task automatic test_illegal();
    do_reset();
    start_seq(0);
    run_instr(7'h7F, 0, 1, 2'd0, 1, 0, 2, 0, 0);
    tot++;
    if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b want=1", illegal); end
  endtask
  task automatic test_async_reset();
    do_reset();
    tot++;
    if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_cleared got=%b want=0", illegal); end
    start_seq(0);
    opcode = 7'h03; MemWrite = 0; ecall_break = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 0; mem_ready = (i == 0);
    end
    #1;
    tot++;
    if (state !== 3'd4 || mem_req !== 1'b1) begin
      bad++; $display("FAIL pre_reset_mem got=%0d/%b want=4/1", state, mem_req);
    end
    #2 rst_n = 0;
    #1;
    tot++;
    if (state !== 3'd0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%0d/%b want=0/0", state, mem_req);
    end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_perf();
    do_reset();
    start_seq(0);
    for (int i = 0; i < 10; i++) run_instr(7'h13, 0, 1, 2'd0, 0, 0, 0, 0, i == 9);
    @(negedge clk);
    start = 0;
    #1;
    tot++;
    if (state !== 3'd0) begin bad++; $display("FAIL perf_idle got=%0d want=0", state); end
    tot++;
    if (cycle_cnt !== 32'(40 * PERF_ON) || instret_cnt !== 32'(10 * PERF_ON)) begin
      bad++; $display("FAIL perf_counters got=%0d/%0d want=%0d/%0d", cycle_cnt, instret_cnt, 40 * PERF_ON, 10 * PERF_ON);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_random();
    test_halt();
    test_timeout();
    test_illegal();
    test_async_reset();
    test_perf();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
